// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: NDIG-digit BCD up/down counter with a prescaled step,
// full-range wrap pulse and a multiplexed active-low 7-segment scan driver.
module bcd_scan_counter #(
    parameter int unsigned NDIG      = 4,
    parameter int unsigned PRESCALE  = 12500000,
    parameter int unsigned SCAN_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up_dn,
    input  logic              clear,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic              blank_lz,
    output logic [4*NDIG-1:0] count_bcd,
    output logic              wrap,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   dig_sel
);

    localparam int unsigned   PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [2:0]    ILAST = 3'(NDIG - 1);

    typedef enum logic [2:0] {
        DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7
    } state_t;

    logic [PW-1:0]        pcnt;
    logic                 step;
    logic [SCAN_BITS-1:0] scnt;
    logic                 scan_wrap;
    state_t               state;
    logic [2:0]           idx;
    logic [4*NDIG-1:0]    count_step;
    logic [4*NDIG-1:0]    count_load;
    logic                 carry;
    logic                 carry_out;
    logic                 zero_run;
    logic [3:0]           cur_dig;
    logic                 cur_blank;
    logic [NDIG-1:0]      sel_next;

    assign step      = en && (pcnt == PLAST);
    assign scan_wrap = &scnt;
    assign idx       = state;
    assign dp        = 1'b1;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Ripple carry/borrow through all digits; carry_out set means every digit wrapped
    always_comb begin
        count_step = count_bcd;
        carry      = 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (up_dn) begin
                    if (count_bcd[4*i +: 4] == 4'd9) begin
                        count_step[4*i +: 4] = 4'd0;
                    end else begin
                        count_step[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (count_bcd[4*i +: 4] == 4'd0) begin
                        count_step[4*i +: 4] = 4'd9;
                    end else begin
                        count_step[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        carry_out = carry;
    end

    // Saturate out-of-range load nibbles to 9
    always_comb begin
        count_load = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            count_load[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Select the scanned digit and decide blanking, walking from the top digit down
    always_comb begin
        cur_dig   = count_bcd[3:0];
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        sel_next  = '1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            zero_run = zero_run && (count_bcd[4*(NDIG-1-k) +: 4] == 4'd0);
            if (idx == 3'(NDIG - 1 - k)) begin
                cur_dig   = count_bcd[4*(NDIG-1-k) +: 4];
                cur_blank = blank_lz && zero_run && (k != NDIG - 1);
                sel_next[NDIG-1-k] = 1'b0;
            end
        end
    end

    // Prescaler: free-runs while enabled, restarts on clear or load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clear || load) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
        end
    end

    // Count register with clear > load > step priority and wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else if (clear) begin
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else if (load) begin
            count_bcd <= count_load;
            wrap      <= 1'b0;
        end else if (step) begin
            count_bcd <= count_step;
            wrap      <= carry_out;
        end else begin
            wrap      <= 1'b0;
        end
    end

    // Free-running scan dwell counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
        end else begin
            scnt <= scnt + SCAN_BITS'(1);
        end
    end

    // Display FSM: advances one digit per dwell wrap, drives registered seg/dig_sel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DIG0;
            seg     <= 7'h7F;
            dig_sel <= '1;
        end else begin
            if (scan_wrap) begin
                state <= (idx == ILAST) ? DIG0 : state_t'(idx + 3'd1);
            end
            seg     <= cur_blank ? 7'h7F : seg_decode(cur_dig);
            dig_sel <= sel_next;
        end
    end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Parametrised multi-digit BCD up/down counter with an integrated multiplexed 7-segment scan driver. Digits count natively in BCD, so no binary-to-BCD conversion stage is needed, and the width scales with `NDIG`. The block adds a prescaled count enable, direction control, synchronous clear and load, wrap detection and leading-zero blanking. It sits between the top-level pad wrapper and the display pins: segment lines go to the output bus, digit selects go to the bidirectional bus.

## Interface
- `NDIG`, 4: number of BCD digits, legal range 1..8.
- `PRESCALE`, 12500000: clock cycles per count step, must be ≥ 1.
- `SCAN_BITS`, 16: scan dwell per digit is 2^`SCAN_BITS` cycles, must be ≥ 1.

- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: count enable. The prescaler runs only while `en`=1.
- `up_dn` in 1: count direction, 1=up, 0=down. Sampled on the step cycle.
- `clear` in 1: synchronous clear of count and prescaler.
- `load` in 1: synchronous load of `load_val`. Also clears the prescaler.
- `load_val` in 4*`NDIG`: BCD load value, digit 0 in bits [3:0].
- `blank_lz` in 1: 1 enables leading-zero blanking.
- `count_bcd` out 4*`NDIG`: current count, registered.
- `wrap` out 1: one-cycle pulse on full-range wrap.
- `seg` out 7: active-low segments, `seg[0]`=a … `seg[6]`=g, registered.
- `dp` out 1: decimal point, constant 1 (off).
- `dig_sel` out `NDIG`: active-low one-hot digit enable, registered.

## Operation
- **Prescaler:** `pcnt` counts 0..`PRESCALE`-1 while `en`=1, then returns to 0.
  - `step` = `en` && `pcnt`==`PRESCALE`-1.
  - When `en`=0, `pcnt` holds.
- **Priority, per cycle:** `clear` > `load` > `step` > hold.
  - `clear`: count → 0, `pcnt` → 0, `wrap` = 0.
  - `load`: each digit ← its `load_val` nibble, except that nibbles greater than 9 load as 9. `pcnt` → 0, `wrap` = 0.
- **Up step:** digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - All digits 9 → all digits 0, and `wrap` pulses.
- **Down step:** digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - All digits 0 → all digits 9, and `wrap` pulses.
- **Carry/borrow:** the chain is combinational across all digits and resolves in one cycle.
- **Scan:**
  - `scnt` is a free-running `SCAN_BITS`-bit counter.
  - Digit index `idx` advances when `scnt` wraps to 0, running 0..`NDIG`-1 and then back to 0.
  - When `NDIG`=1, `idx` stays at 0.
- **Display state machine:** one state per digit, DIG0 → DIG1 → … → DIG(`NDIG`-1) → DIG0.
  - Transitions happen only on a `scnt` wrap.
  - `clear` and `load` do not affect the scan.
- **Digit drive:** `dig_sel[idx]` = 0 and all other bits = 1. `seg` shows the decoded `count_bcd` digit `idx`.
- **Decode:** standard 0–9 patterns, with 6 and 9 drawn with their tails. Codes 10–15 never occur.
- **Leading-zero blanking:** digit i > 0 is blanked when `blank_lz`=1 and digits i..`NDIG`-1 are all 0.
  - A blanked digit drives `seg`=7'h7F while its `dig_sel` bit still asserts.
  - Digit 0 is never blanked.

## Timing
- **Reset values:**
  - `count_bcd`=0, `pcnt`=0, `scnt`=0, `idx`=0, `wrap`=0.
  - `seg`=7'h7F, `dig_sel`=all ones, `dp`=1.
- **Count latency:** `count_bcd` changes on the clock edge that ends the `step`, `load` or `clear` cycle, i.e. visible one cycle later.
- **`wrap`:** asserted in the same cycle `count_bcd` shows the wrapped value, for exactly 1 cycle.
- **Step rate:** with `en` held at 1, one step every `PRESCALE` cycles. The first step comes `PRESCALE` cycles after reset release or after a `clear`/`load`.
- **Display latency:** `seg`/`dig_sel` are registered, so they lag `idx` and `count_bcd` by 1 cycle.
  - The first valid digit 0 appears 1 cycle after reset release.
- **Dwell:** each digit stays active for exactly 2^`SCAN_BITS` cycles. The full frame lasts `NDIG`·2^`SCAN_BITS` cycles.
- **Direction change:** `up_dn` takes effect on the next `step`. It has no effect on the prescaler.
- **Simultaneous `load` and `step`:** load wins and the step is lost.
- **`en` dropped at `pcnt`==`PRESCALE`-1:** no step; the prescaler holds.
- **Reset mid-operation:** all registers return to their reset values immediately, independent of `clk`.

## Test plan
Unless stated otherwise: `NDIG`=3, `PRESCALE`=4, `SCAN_BITS`=2.

1. **Reset and first steps:** reset, then `en`=1, `up_dn`=1. `count_bcd` reads 0x000, 0x001 and 0x002 at cycles 4 and 8 after release; `seg`=7'h7F during reset.
2. **Up wrap:** load 0x998, then count up. Sequence 0x999 → 0x000 with a single-cycle `wrap`. Load 0x0F9 reads back 0x099.
3. **Down wrap:** load 0x001, `up_dn`=0. Sequence 0x000 → 0x999 with `wrap`=1 on the 0x999 cycle.
4. **Scan order:** count held at 0x123. `dig_sel` cycles 110 → 101 → 011, 4 cycles each. `seg` shows 3, 2, 1, with active-low values 7'h30, 7'h24, 7'h79.
5. **Leading-zero blanking:** count 0x005, `blank_lz`=1. Digits 2 and 1 drive `seg`=7'h7F and digit 0 drives 7'h12. With `blank_lz`=0, digits 2 and 1 show 7'h40.
6. **Priority and reset:** `clear` and `load` together → count 0x000. Load on the step cycle → `load_val` exactly, no increment. Drop `rst_n` mid-count → outputs return to reset values before the next `clk` edge.
